// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t                - arbiter FSM state encoding
//   BYTE_W                 - width of a transmitted byte
//   DEFAULT_TIMEOUT_CYCLES - default lock-release timeout (1 ms at 50 MHz)
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a shared UART transmitter.
// One byte is granted per FSM pass (IDLE -> START -> HOLD -> WAIT).
// Ties between the requesters are broken round-robin. A byte with last=0
// locks the transmitter to its requester until that requester sends last=1.
//
// Ports:
//   clock                  system clock, rising edge
//   rst                    synchronous active-high reset
//   reqN_valid/data/last   requester N byte offer (N = 0, 1)
//   reqN_ready             one-cycle accept strobe to requester N
//   cts_n                  host clear-to-send, active low
//   tx_busy                transmitter is shifting
//   tx_start, tx_data      start strobe and byte to the transmitter
//   owner                  requester of the current or last byte
//   locked                 packet lock held by owner
//   timeout                one-cycle pulse when the lock is released by timeout
//
// Build option: define UART_TX_ARBITER_TIMEOUT_EN to release a stale lock
// after TIMEOUT_CYCLES idle cycles without a byte from the owner. Without it
// the lock is held indefinitely and timeout is tied low.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              cts_n,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              owner,
  output logic              locked,
  output logic              timeout
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic              locked_q, locked_d;

  logic              owner_valid;
  logic              grant_any;
  logic              grant_sel;
  logic              timeout_hit;

  assign owner_valid = owner_q ? req1_valid : req0_valid;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_count_en;

  assign tmo_count_en = (state_q == ST_IDLE) && locked_q && !owner_valid;
  assign timeout_hit  = tmo_count_en && (tmo_cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 16'd1;
    if (!tmo_count_en || timeout_hit) tmo_cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    locked_d   = locked_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_start   = 1'b0;
    grant_any  = 1'b0;
    grant_sel  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!tx_busy && !cts_n) begin
          if (locked_q) begin
            // Only the lock owner may continue its packet.
            grant_any = owner_valid;
            grant_sel = owner_q;
          end else if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_sel = ~rr_last_q;
          end else if (req0_valid || req1_valid) begin
            grant_any = 1'b1;
            grant_sel = req1_valid;
          end
        end

        if (grant_any) begin
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          tx_data_d  = grant_sel ? req1_data : req0_data;
          owner_d    = grant_sel;
          rr_last_d  = grant_sel;
          locked_d   = ~(grant_sel ? req1_last : req0_last);
          state_d    = ST_START;
        end

        // A timeout only fires while the owner is silent, so it can never
        // coincide with a grant in the same cycle.
        if (timeout_hit) locked_d = 1'b0;
      end
      ST_START: begin
        tx_start = 1'b1;
        state_d  = ST_HOLD;
      end
      // Gives the transmitter a cycle to raise tx_busy after the start strobe.
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: if (!tx_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      locked_q  <= locked_d;
    end
  end

  assign tx_data = tx_data_q;
  assign owner   = owner_q;
  assign locked  = locked_q;
  assign timeout = timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table covering
// single grants, round robin, packet lock, cts_n and tx_busy gating, plus
// hand sequences for lock timeout and reset in the middle of a byte.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       cts_n, tx_busy, tx_start, owner, locked, timeout;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clock      (clock),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .cts_n      (cts_n),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .owner      (owner),
    .locked     (locked),
    .timeout    (timeout)
  );

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       cts;
    logic       busy;
    logic [13:0] exp;  // {ready0, ready1, tx_start, tx_data, owner, locked, timeout}
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0,
                              logic v1, logic [7:0] d1, logic l1,
                              logic cts, logic busy,
                              logic r0, logic r1, logic st, logic [7:0] data,
                              logic own, logic lck);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.cts = cts; v.busy = busy;
    v.exp = {r0, r1, st, data, own, lck, 1'b0};
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {req0_ready, req1_ready, tx_start, tx_data, owner, locked, timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic cts, input logic busy);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    cts_n = cts; tx_busy = busy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Expected outputs observed during each cycle, before its closing edge.
    //             v0 d0    l0 v1 d1    l1 cts bsy  r0 r1 st data  own lck
    vecs[0]  = mk(1, 8'h41, 1, 0, 8'h00, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 8'h41, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h41, 0, 0);
    vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 8'h41, 0, 0);
    vecs[4]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 0, 8'h41, 0, 0);
    vecs[5]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 1, 0, 8'h41, 0, 0);
    vecs[6]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 1, 8'hB1, 1, 0);
    vecs[7]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 0, 8'hB1, 1, 0);
    vecs[8]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 0, 8'hB1, 1, 0);
    vecs[9]  = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   1, 0, 0, 8'hB1, 1, 0);
    vecs[10] = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 1, 8'hA0, 0, 0);
    vecs[11] = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[12] = mk(1, 8'hA0, 1, 1, 8'hB1, 1, 0, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[13] = mk(1, 8'hA0, 1, 1, 8'h10, 0, 0, 0,   0, 1, 0, 8'hA0, 0, 0);
    vecs[14] = mk(1, 8'hA0, 1, 1, 8'h10, 0, 0, 0,   0, 0, 1, 8'h10, 1, 1);
    vecs[15] = mk(1, 8'hA0, 1, 1, 8'h10, 0, 0, 0,   0, 0, 0, 8'h10, 1, 1);
    vecs[16] = mk(1, 8'hA0, 1, 1, 8'h10, 0, 0, 0,   0, 0, 0, 8'h10, 1, 1);
    vecs[17] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h10, 1, 1);
    vecs[18] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h10, 1, 1);
    vecs[19] = mk(1, 8'hA0, 1, 1, 8'h11, 1, 0, 0,   0, 1, 0, 8'h10, 1, 1);
    vecs[20] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   0, 0, 1, 8'h11, 1, 0);
    vecs[21] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h11, 1, 0);
    vecs[22] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h11, 1, 0);
    vecs[23] = mk(1, 8'hA0, 1, 0, 8'h00, 0, 0, 0,   1, 0, 0, 8'h11, 1, 0);
    vecs[24] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 8'hA0, 0, 0);
    vecs[25] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[26] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[27] = mk(1, 8'h5A, 1, 0, 8'h00, 0, 1, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[28] = mk(1, 8'h5A, 1, 0, 8'h00, 0, 1, 0,   0, 0, 0, 8'hA0, 0, 0);
    vecs[29] = mk(1, 8'h5A, 1, 0, 8'h00, 0, 0, 0,   1, 0, 0, 8'hA0, 0, 0);
    vecs[30] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 1, 8'h5A, 0, 0);
    vecs[31] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1,   0, 0, 0, 8'h5A, 0, 0);
    vecs[32] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1,   0, 0, 0, 8'h5A, 0, 0);
    vecs[33] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 8'h5A, 0, 0);
    vecs[34] = mk(1, 8'h66, 1, 0, 8'h00, 0, 1, 0,   0, 0, 0, 8'h5A, 0, 0);
    vecs[35] = mk(1, 8'h66, 1, 0, 8'h00, 0, 0, 1,   0, 0, 0, 8'h5A, 0, 0);
    vecs[36] = mk(1, 8'h66, 1, 0, 8'h00, 0, 0, 0,   1, 0, 0, 8'h5A, 0, 0);
    vecs[37] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 8'h66, 0, 0);

    // Reset, checked while rst is still asserted.
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    tick();
    tick();
    @(negedge clock);
    check("reset_state", 32'(outs()), 32'(14'h0000));
    tick();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1, vecs[i].l1,
            vecs[i].cts, vecs[i].busy);
      @(negedge clock);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
    end

    // Drain: HOLD, WAIT -> IDLE.
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    tick();
    tick();

    // Lock by requester 1, then leave it silent while requester 0 waits.
    drive(0, 8'h00, 0, 1, 8'h77, 0, 0, 0);
    @(negedge clock);
    check("lock_grant_r1", 32'(req1_ready), 32'd1);
    tick();
    drive(1, 8'h88, 1, 0, 8'h00, 0, 0, 0);
    tick();
    tick();
    tick();
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check($sformatf("tmo_pulse_k%0d", k), 32'({timeout, req0_ready}),
            32'({(k == 16), 1'b0}));
      tick();
    end
    @(negedge clock);
    check("tmo_release", 32'({locked, req0_ready, timeout}), 32'(3'b010));
    tick();
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      check($sformatf("no_tmo_k%0d", k), 32'({timeout, req0_ready, locked}),
            32'(3'b001));
      tick();
    end
`endif

    // Back to IDLE, then reset in the middle of a locked byte's WAIT.
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    repeat (4) tick();
    drive(0, 8'h00, 0, 1, 8'h99, 0, 0, 0);
    @(negedge clock);
    check("pre_rst_grant", 32'(req1_ready), 32'd1);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    tick();
    tick();
    @(negedge clock);
    check("pre_rst_wait", 32'({tx_start, tx_data, owner, locked}), 32'({1'b0, 8'h99, 1'b1, 1'b1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clock);
    check("post_rst_state", 32'(outs()), 32'(14'h0000));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      check($sformatf("post_rst_no_start%0d", k), 32'(tx_start), 32'd0);
    end
    tick();
    drive(1, 8'hC3, 1, 1, 8'h3C, 1, 0, 0);
    @(negedge clock);
    check("post_rst_tie_r0", 32'({req0_ready, req1_ready}), 32'(2'b10));
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clock);
    check("post_rst_start", 32'({tx_start, tx_data, owner}), 32'({1'b1, 8'hC3, 1'b0}));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd50000, lock-release timeout in clock cycles (1 ms at 50 MHz).
REQ-002 clock  input  1  system clock, 50 MHz, rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester n offers a byte.
REQ-005 req0_data, req1_data  input  8 each  offered byte.
REQ-006 req0_last, req1_last  input  1 each  offered byte ends requester's packet.
REQ-007 req0_ready, req1_ready  output  1 each  one-cycle accept strobe.
REQ-008 cts_n  input  1  clear-to-send from host, active-low.
REQ-009 tx_busy  input  1  shared UART transmitter is shifting.
REQ-010 tx_start  output  1  one-cycle start strobe to the transmitter.
REQ-011 tx_data  output  8  byte to the transmitter.
REQ-012 owner  output  1  requester of the current or last byte.
REQ-013 locked  output  1  packet lock is held by owner.
REQ-014 timeout  output  1  one-cycle lock-release-by-timeout pulse.

Function
REQ-015 FSM states IDLE, START, HOLD, WAIT; one byte per pass.
REQ-016 IDLE: select only when tx_busy=0 and cts_n=0; otherwise stay, no ready.
REQ-017 IDLE unlocked: one valid -> that requester; both valid -> requester != rr_last (round robin).
REQ-018 IDLE locked: only owner is eligible; the other requester is ignored even if valid.
REQ-019 On select: reqN_ready=1 for that cycle, tx_data<=reqN_data, owner<=N, rr_last<=N, -> START.
REQ-020 Byte accepted with last=0 sets locked=1; last=1 clears locked.
REQ-021 START: tx_start=1 exactly one cycle, -> HOLD.
REQ-022 HOLD: one cycle, tx_busy ignored, -> WAIT.
REQ-023 WAIT: stay while tx_busy=1; tx_busy=0 -> IDLE.
REQ-024 Latency: valid with idle path -> ready same cycle, tx_start next cycle; back-to-back bytes spaced >= 4 cycles + busy time.
REQ-025 tx_data stable from START until next accept.
REQ-026 At most one ready per cycle; never ready outside IDLE.
REQ-027 cts_n rising mid-byte does not abort the byte; blocks only next selection.

Reset
REQ-028 rst: state IDLE, tx_start=0, tx_data=8'h00, readys=0, owner=0, rr_last=1 (requester 0 wins first tie), locked=0, timeout=0, timeout counter=0.
REQ-029 rst mid-byte abandons byte; no tx_start afterwards until new selection.

Configuration
REQ-030 Macro UART_TX_ARBITER_TIMEOUT_EN defined: counter increments each cycle in IDLE while locked=1 and owner's valid=0; clears otherwise.
REQ-031 Counter reaching TIMEOUT_CYCLES-1: locked<=0, timeout=1 one cycle, counter<=0.
REQ-032 Macro undefined: no counter, timeout tied 0, lock held indefinitely.

Structure
REQ-033 Shared package uart_pkg: FSM state encoding constants, byte width 8, default TIMEOUT_CYCLES.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Reset then req0 valid 8'h41 last=1, cts_n=0 -> req0_ready same cycle, tx_start next cycle, tx_data=8'h41, owner=0, locked=0.
REQ-036 Both valid, last=1 each, repeated -> grants 0,1,0,1 alternating.
REQ-037 req1 sends 8'h10 last=0, req0 valid throughout -> locked=1, req0 starved until req1 sends 8'h11 last=1, then req0 granted.
REQ-038 cts_n=1 with req0 valid -> no ready; cts_n=0 -> accept in that cycle; cts_n=1 during WAIT -> current byte completes.
REQ-039 TIMEOUT_EN, TIMEOUT_CYCLES=16: lock held, owner valid=0 for 16 idle cycles -> timeout pulse, locked=0, other requester granted next.
REQ-040 rst asserted in WAIT -> next cycle IDLE, all outputs at reset values.
